// File: rtl/puf_pkg.sv
// puf_pkg: shared types and constants for the RO PUF sequencer.
//   state_t    - sequencer states (IDLE, CLEAR, RUN, DONE)
//   CHALL_STEP - increment applied to the challenge for each successive bit
//   vote_cnt_t - 2-bit counter type used by the majority-vote build
//                (PUF_MAJORITY_EN)
package puf_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        RUN   = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Adds one to both mux-select nibbles of the challenge at once.
    localparam logic [7:0] CHALL_STEP = 8'h11;

    typedef logic [1:0] vote_cnt_t;

endpackage

// File: rtl/puf_wait_timer.sv
// puf_wait_timer: loadable down-counter with an expire flag.
//   clk, rst_n - clock, asynchronous active-low reset (count returns to 0)
//   load       - load load_val (takes priority over dec)
//   load_val   - value to load; the counter expires load_val+1 cycles later
//   dec        - decrement by one, saturating at zero
//   expired    - high while the count is zero
module puf_wait_timer #(
    parameter int W = 10
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         expired
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (dec && (cnt_q != '0)) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired = (cnt_q == '0);

endmodule

// File: rtl/puf_ctrl.sv
// puf_ctrl: sequencer around a single-bit RO PUF cell. Generates N_BITS
// challenges from a seed (seed + 8'h11*i), drives the cell through a
// CLEAR (puf_rst held SETTLE_CYC cycles) then RUN (puf_en) phase for each,
// and shifts the response bits into an N_BITS-wide word.
//
// Optional build macro: PUF_MAJORITY_EN - each challenge is evaluated three
// times and the majority of the three results is stored (a timed-out
// evaluation counts as 0).
//
// Ports:
//   clk, rst_n   - clock, asynchronous active-low reset
//   start, seed  - begin a run (sampled only in IDLE) with the given base challenge
//   puf_chall    - challenge to the cell
//   puf_rst      - synchronous clear to the cell (high outside RUN)
//   puf_en       - ring-oscillator enable (high only in RUN)
//   puf_resp     - response bit from the cell
//   puf_finish   - race-complete flag from the cell
//   resp_word    - last completed response word (first challenge in the MSB)
//   busy         - high in any state except IDLE
//   done         - one-cycle pulse in DONE; resp_word takes the new word at its end
//   timeout_err  - sticky: some evaluation of the last run timed out
module puf_ctrl
    import puf_pkg::*;
#(
    parameter int N_BITS      = 8,
    parameter int SETTLE_CYC  = 4,
    parameter int TIMEOUT_CYC = 1023
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [7:0]        seed,
    output logic [7:0]        puf_chall,
    output logic              puf_rst,
    output logic              puf_en,
    input  logic              puf_resp,
    input  logic              puf_finish,
    output logic [N_BITS-1:0] resp_word,
    output logic              busy,
    output logic              done,
    output logic              timeout_err
);

    localparam int TMAX = (TIMEOUT_CYC > SETTLE_CYC) ? TIMEOUT_CYC : SETTLE_CYC;
    localparam int TW   = $clog2(TMAX + 1);
    localparam int IW   = (N_BITS > 1) ? $clog2(N_BITS) : 1;

    localparam logic [TW-1:0] SETTLE_LOAD  = TW'(SETTLE_CYC - 1);
    localparam logic [TW-1:0] TIMEOUT_LOAD = TW'(TIMEOUT_CYC - 1);
    localparam logic [IW-1:0] LAST_IDX     = IW'(N_BITS - 1);

    state_t            state_q, state_d;
    logic [7:0]        seed_q, seed_d;
    logic [IW-1:0]     idx_q, idx_d;
    logic [N_BITS-1:0] sreg_q, sreg_d;
    logic [N_BITS-1:0] resp_word_q, resp_word_d;
    logic              timeout_err_q, timeout_err_d;

    logic              tmr_load;
    logic              tmr_dec;
    logic [TW-1:0]     tmr_val;
    logic              tmr_exp;

    logic              eval_end;
    logic              eval_bit;
    logic              commit;
    logic              store_bit;
    logic [7:0]        idx_ext;

`ifdef PUF_MAJORITY_EN
    vote_cnt_t         vote_q, vote_d;
    vote_cnt_t         ones_q, ones_d;
    vote_cnt_t         ones_sum;
`endif

    puf_wait_timer #(
        .W (TW)
    ) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (tmr_load),
        .load_val (tmr_val),
        .dec      (tmr_dec),
        .expired  (tmr_exp)
    );

    // An evaluation ends on finish or on timer expiry; finish wins a tie,
    // and a timed-out evaluation yields 0.
    assign eval_end = (state_q == RUN) && (puf_finish || tmr_exp);
    assign eval_bit = puf_finish & puf_resp;

`ifdef PUF_MAJORITY_EN
    // vote_q counts completed evaluations of the current challenge (0..2);
    // the bit is committed on the third.
    assign ones_sum  = ones_q + vote_cnt_t'(eval_bit);
    assign commit    = eval_end && (vote_q == 2'd2);
    assign store_bit = (ones_sum >= 2'd2);
`else
    assign commit    = eval_end;
    assign store_bit = eval_bit;
`endif

    always_comb begin
        state_d       = state_q;
        seed_d        = seed_q;
        idx_d         = idx_q;
        sreg_d        = sreg_q;
        resp_word_d   = resp_word_q;
        timeout_err_d = timeout_err_q;
        tmr_load      = 1'b0;
        tmr_dec       = 1'b0;
        tmr_val       = SETTLE_LOAD;
`ifdef PUF_MAJORITY_EN
        vote_d        = vote_q;
        ones_d        = ones_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    seed_d        = seed;
                    idx_d         = '0;
                    sreg_d        = '0;
                    timeout_err_d = 1'b0;
                    tmr_load      = 1'b1;
                    state_d       = CLEAR;
`ifdef PUF_MAJORITY_EN
                    vote_d        = '0;
                    ones_d        = '0;
`endif
                end
            end
            CLEAR: begin
                if (tmr_exp) begin
                    tmr_load = 1'b1;
                    tmr_val  = TIMEOUT_LOAD;
                    state_d  = RUN;
                end else begin
                    tmr_dec = 1'b1;
                end
            end
            RUN: begin
                if (eval_end) begin
                    if (!puf_finish) begin
                        timeout_err_d = 1'b1;
                    end
                    // Default: back to CLEAR for the next evaluation.
                    tmr_load = 1'b1;
                    state_d  = CLEAR;
`ifdef PUF_MAJORITY_EN
                    vote_d   = vote_q + 2'd1;
                    ones_d   = ones_sum;
`endif
                    if (commit) begin
                        sreg_d = N_BITS'({sreg_q, store_bit});
`ifdef PUF_MAJORITY_EN
                        vote_d = '0;
                        ones_d = '0;
`endif
                        if (idx_q == LAST_IDX) begin
                            tmr_load = 1'b0;
                            state_d  = DONE;
                        end else begin
                            idx_d = idx_q + IW'(1);
                        end
                    end
                end else begin
                    tmr_dec = 1'b1;
                end
            end
            DONE: begin
                resp_word_d = sreg_q;
                state_d     = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            seed_q        <= '0;
            idx_q         <= '0;
            sreg_q        <= '0;
            resp_word_q   <= '0;
            timeout_err_q <= 1'b0;
`ifdef PUF_MAJORITY_EN
            vote_q        <= '0;
            ones_q        <= '0;
`endif
        end else begin
            state_q       <= state_d;
            seed_q        <= seed_d;
            idx_q         <= idx_d;
            sreg_q        <= sreg_d;
            resp_word_q   <= resp_word_d;
            timeout_err_q <= timeout_err_d;
`ifdef PUF_MAJORITY_EN
            vote_q        <= vote_d;
            ones_q        <= ones_d;
`endif
        end
    end

    // Challenge is a pure function of the latched seed and index, so it reads
    // 0 out of reset and stays stable through CLEAR and RUN.
    assign idx_ext     = 8'(idx_q);
    assign puf_chall   = seed_q + (CHALL_STEP * idx_ext);

    assign puf_en      = (state_q == RUN);
    assign puf_rst     = (state_q != RUN);
    assign busy        = (state_q != IDLE);
    assign done        = (state_q == DONE);
    assign resp_word   = resp_word_q;
    assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_puf_ctrl.sv
// tb_puf_ctrl: directed bench for puf_ctrl with a behavioural PUF cell.
// The cell model finishes in the third RUN cycle; its response is taken from
// a per-run pattern indexed by the challenge's low nibble (equal to the bit
// index for seeds with a zero low nibble). Honors PUF_MAJORITY_EN.
module tb_puf_ctrl;

    localparam int N_BITS      = 8;
    localparam int SETTLE_CYC  = 4;
    localparam int TIMEOUT_CYC = 16;
`ifdef PUF_MAJORITY_EN
    localparam int EV = 3;
`else
    localparam int EV = 1;
`endif

    logic              clk = 1'b0;
    logic              rst_n;
    logic              start;
    logic [7:0]        seed;
    logic [7:0]        puf_chall;
    logic              puf_rst;
    logic              puf_en;
    logic              puf_resp;
    logic              puf_finish;
    logic [N_BITS-1:0] resp_word;
    logic              busy;
    logic              done;
    logic              timeout_err;

    puf_ctrl #(
        .N_BITS      (N_BITS),
        .SETTLE_CYC  (SETTLE_CYC),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .seed        (seed),
        .puf_chall   (puf_chall),
        .puf_rst     (puf_rst),
        .puf_en      (puf_en),
        .puf_resp    (puf_resp),
        .puf_finish  (puf_finish),
        .resp_word   (resp_word),
        .busy        (busy),
        .done        (done),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    // PUF cell model
    logic [7:0] pat      = 8'h00;
    logic       hang_en  = 1'b0;
    logic [3:0] hang_idx = 4'd0;
    logic       maj_mode = 1'b0;
    int         run_cyc  = 0;
    int         ev_cnt   = 0;

    always @(posedge clk) begin
        if (puf_rst) run_cyc <= 0;
        else if (puf_en) run_cyc <= run_cyc + 1;
        if (!busy) ev_cnt <= 0;
        else if (puf_en && puf_finish) ev_cnt <= (ev_cnt == 2) ? 0 : ev_cnt + 1;
    end

    always_comb begin
        puf_finish = puf_en && (run_cyc == 2) && !(hang_en && (puf_chall[3:0] == hang_idx));
        if (maj_mode) puf_resp = (ev_cnt != 1);
        else          puf_resp = pat[3'd7 - puf_chall[2:0]];
    end

    // Bookkeeping
    int         errors = 0;
    int         checks = 0;
    int         cyc, n_done, n_clear, bad_clr;
    logic       overlap, timed_out;
    logic [7:0] ch_log [0:31];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Watches one run at the falling edge until done (bounded), logging each
    // CLEAR segment's challenge and length; optionally pulses start mid-run.
    task automatic run_capture(input int max_cyc, input int extra_start_at);
        int clr_len;
        clr_len = 0; cyc = 0; n_done = 0; n_clear = 0; bad_clr = 0;
        overlap = 1'b0; timed_out = 1'b0;
        while (n_done == 0 && cyc < max_cyc) begin
            @(negedge clk);
            cyc++;
            start = (cyc == extra_start_at);
            if (puf_en && puf_rst) overlap = 1'b1;
            if (done) n_done++;
            if (busy && puf_rst && !done) begin
                if (clr_len == 0) begin
                    if (n_clear < 32) ch_log[n_clear] = puf_chall;
                    n_clear++;
                end
                clr_len++;
            end else begin
                if (clr_len != 0 && clr_len != SETTLE_CYC) bad_clr++;
                clr_len = 0;
            end
        end
        start = 1'b0;
        if (n_done == 0) timed_out = 1'b1;
        repeat (3) begin
            @(negedge clk);
            if (done) n_done++;
        end
    endtask

    task automatic do_run(input string tag, input logic [7:0] s, input logic [7:0] p,
                          input logic hang, input logic [7:0] exp_word,
                          input logic exp_terr, input int extra_start_at);
        logic [7:0] e;
        pat = p; hang_en = hang; hang_idx = 4'd2;
        @(negedge clk);
        seed  = s;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        chk({tag, "_busy_on_start"}, busy, 1'b1);
        chk({tag, "_terr_cleared"}, timeout_err, 1'b0);
        run_capture(2000, extra_start_at);
        chk({tag, "_no_timeout"}, timed_out, 1'b0);
        chk({tag, "_one_done"}, n_done, 1);
        chk({tag, "_resp_word"}, resp_word, exp_word);
        chk({tag, "_timeout_err"}, timeout_err, exp_terr);
        chk({tag, "_n_clear"}, n_clear, N_BITS * EV);
        chk({tag, "_clear_len"}, bad_clr, 0);
        chk({tag, "_en_rst_overlap"}, overlap, 1'b0);
        chk({tag, "_idle_after"}, busy, 1'b0);
        for (int i = 0; i < N_BITS * EV; i++) begin
            e = s + 8'(17 * (i / EV));
            chk($sformatf("%s_chall%0d", tag, i), ch_log[i], e);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int dn;
        rst_n = 1'b0;
        start = 1'b0;
        seed  = 8'h00;
        #1;
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_resp_word", resp_word, 8'h00);
        chk("rst_puf_rst", puf_rst, 1'b1);
        chk("rst_puf_en", puf_en, 1'b0);
        chk("rst_puf_chall", puf_chall, 8'h00);
        chk("rst_timeout_err", timeout_err, 1'b0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle_no_start", busy, 1'b0);

        // Alternating 1,0,... from seed 00
        do_run("t1", 8'h00, 8'hAA, 1'b0, 8'hAA, 1'b0, 0);
        // Wrapping challenges from seed F0
        do_run("t2", 8'hF0, 8'h3C, 1'b0, 8'h3C, 1'b0, 0);
        // Index 2 never finishes: that bit is 0 and the error is sticky
        do_run("t3", 8'h00, 8'hFF, 1'b1, 8'hDF, 1'b1, 0);
        chk("t3_terr_held", timeout_err, 1'b1);
        // start pulsed mid-run is ignored; new run clears timeout_err
        do_run("t4", 8'h20, 8'h5A, 1'b0, 8'h5A, 1'b0, 20);

        // Reset during RUN of index 5
        pat = 8'hFF; hang_en = 1'b0;
        @(negedge clk);
        seed = 8'h00; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        cyc = 0;
        while (!(puf_en && puf_chall == 8'h55) && cyc < 1000) begin
            @(negedge clk);
            cyc++;
        end
        chk("t5_reached_idx5", puf_en && (puf_chall == 8'h55), 1'b1);
        rst_n = 1'b0;
        #1;
        chk("t5_busy", busy, 1'b0);
        chk("t5_done", done, 1'b0);
        chk("t5_resp_word", resp_word, 8'h00);
        chk("t5_puf_rst", puf_rst, 1'b1);
        chk("t5_puf_en", puf_en, 1'b0);
        chk("t5_puf_chall", puf_chall, 8'h00);
        chk("t5_timeout_err", timeout_err, 1'b0);
        dn = 0;
        repeat (3) begin
            @(negedge clk);
            if (done) dn++;
        end
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            if (done) dn++;
        end
        chk("t5_no_done", dn, 0);
        chk("t5_stays_idle", busy, 1'b0);
        do_run("t5b", 8'h00, 8'h81, 1'b0, 8'h81, 1'b0, 0);

`ifdef PUF_MAJORITY_EN
        // Each challenge answers 1,0,1 across its three evaluations
        maj_mode = 1'b1;
        do_run("t6", 8'h00, 8'h00, 1'b0, 8'hFF, 1'b0, 0);
        maj_mode = 1'b0;
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
